// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
package spi_arb_pkg;

  localparam int unsigned ACK_TIMEOUT   = 8;
  localparam int unsigned ACK_TIMEOUT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned LEN_W         = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic              mode;
    logic              lock;
  } req_t;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational two-way round-robin picker with lock override.
module spi_arb_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       lock_en,
  input  logic       lock_id,
  output logic       grant_id,
  output logic       grant_vld
);

  always_comb begin
    grant_id  = 1'b0;
    grant_vld = 1'b0;
    // A held lock makes the owner the only candidate, even when it is not requesting.
    if (lock_en) begin
      grant_id  = lock_id;
      grant_vld = valid[lock_id];
    end else if (valid == 2'b11) begin
      grant_id  = ~last;
      grant_vld = 1'b1;
    end else if (valid[0]) begin
      grant_id  = 1'b0;
      grant_vld = 1'b1;
    end else if (valid[1]) begin
      grant_id  = 1'b1;
      grant_vld = 1'b1;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_controller between two requesters.
// Optional per-owner transfer counters when SPI_ARB_STATS_EN is defined.
module spi_bus_arbiter
  import spi_arb_pkg::*;
(
  input  logic              CLK_25MHz,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  input  logic [DATA_W-1:0] REQ0_DATA,
  input  logic [LEN_W-1:0]  REQ0_LEN,
  input  logic              REQ0_MODE,
  input  logic              REQ0_LOCK,
  output logic              REQ0_ACK,
  input  logic              REQ1_VALID,
  input  logic [DATA_W-1:0] REQ1_DATA,
  input  logic [LEN_W-1:0]  REQ1_LEN,
  input  logic              REQ1_MODE,
  input  logic              REQ1_LOCK,
  output logic              REQ1_ACK,
  output logic [DATA_W-1:0] SPI_DATA,
  output logic [LEN_W-1:0]  SPI_LEN,
  output logic              SPI_MODE,
  output logic              SPI_WE,
  input  logic              SPI_READY,
  output logic [1:0]        GRANT,
  output logic              BUSY,
  output logic              TIMEOUT_ERR
`ifdef SPI_ARB_STATS_EN
  ,
  output logic [15:0]       XFER_CNT0,
  output logic [15:0]       XFER_CNT1
`endif
);

  state_t                   state, state_nxt;
  logic                     owner, owner_nxt;
  logic                     last, last_nxt;
  logic                     lock_en, lock_nxt;
  logic                     cap_lock, cap_lock_nxt;
  logic [ACK_TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic                     tmo_nxt;
  logic                     we_nxt;
  logic [1:0]               ack_nxt;
  logic [1:0]               grant_nxt;
  logic                     pick_id, pick_vld;
  req_t                     req0, req1, sel;

  assign req0 = {REQ0_DATA, REQ0_LEN, REQ0_MODE, REQ0_LOCK};
  assign req1 = {REQ1_DATA, REQ1_LEN, REQ1_MODE, REQ1_LOCK};
  assign sel  = owner ? req1 : req0;

  // Lock owner is always the last served requester.
  spi_arb_rr_pick u_pick (
    .valid     ({REQ1_VALID, REQ0_VALID}),
    .last      (last),
    .lock_en   (lock_en),
    .lock_id   (last),
    .grant_id  (pick_id),
    .grant_vld (pick_vld)
  );

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_nxt     = last;
    lock_nxt     = lock_en;
    cap_lock_nxt = cap_lock;
    cnt_nxt      = cnt;
    tmo_nxt      = TIMEOUT_ERR;
    we_nxt       = 1'b0;
    ack_nxt      = 2'b00;
    grant_nxt    = 2'b00;

    case (state)
      IDLE: begin
        if (SPI_READY && pick_vld) begin
          owner_nxt = pick_id;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        we_nxt       = 1'b1;
        ack_nxt      = owner ? 2'b10 : 2'b01;
        cap_lock_nxt = sel.lock;
        cnt_nxt      = '0;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!SPI_READY) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == ACK_TIMEOUT_W'(ACK_TIMEOUT - 1)) begin
          tmo_nxt   = 1'b1;
          lock_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (SPI_READY) begin
          last_nxt  = owner;
          lock_nxt  = cap_lock;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != IDLE) begin
      grant_nxt = owner_nxt ? 2'b10 : 2'b01;
    end else if (lock_nxt) begin
      grant_nxt = last_nxt ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      lock_en     <= 1'b0;
      cap_lock    <= 1'b0;
      cnt         <= '0;
      TIMEOUT_ERR <= 1'b0;
      SPI_WE      <= 1'b0;
      REQ0_ACK    <= 1'b0;
      REQ1_ACK    <= 1'b0;
      GRANT       <= 2'b00;
      BUSY        <= 1'b0;
      SPI_DATA    <= '0;
      SPI_LEN     <= '0;
      SPI_MODE    <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last        <= last_nxt;
      lock_en     <= lock_nxt;
      cap_lock    <= cap_lock_nxt;
      cnt         <= cnt_nxt;
      TIMEOUT_ERR <= tmo_nxt;
      SPI_WE      <= we_nxt;
      REQ0_ACK    <= ack_nxt[0];
      REQ1_ACK    <= ack_nxt[1];
      GRANT       <= grant_nxt;
      BUSY        <= (state_nxt != IDLE);
      // Word registers hold their value until the next capture.
      if (state == ISSUE) begin
        SPI_DATA <= sel.data;
        SPI_LEN  <= sel.len;
        SPI_MODE <= sel.mode;
      end
    end
  end

`ifdef SPI_ARB_STATS_EN
  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      XFER_CNT0 <= '0;
      XFER_CNT1 <= '0;
    end else if (state == WAIT_DONE && SPI_READY) begin
      if (owner) XFER_CNT1 <= XFER_CNT1 + 16'd1;
      else       XFER_CNT0 <= XFER_CNT0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: requester queues, a simple spi_controller model and an ownership model.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  req_t        cur0 = '0, cur1 = '0;
  logic        spi_ready = 1'b1;
  logic        ack0, ack1, spi_we, spi_mode, busy, tmo;
  logic [15:0] spi_data;
  logic [3:0]  spi_len;
  logic [1:0]  grant;
`ifdef SPI_ARB_STATS_EN
  logic [15:0] xc0, xc1;
`endif

  always #20 clk = ~clk;

  spi_bus_arbiter dut (
    .CLK_25MHz (clk),        .RESET      (rst),
    .REQ0_VALID(v0),         .REQ0_DATA  (cur0.data), .REQ0_LEN(cur0.len),
    .REQ0_MODE (cur0.mode),  .REQ0_LOCK  (cur0.lock), .REQ0_ACK(ack0),
    .REQ1_VALID(v1),         .REQ1_DATA  (cur1.data), .REQ1_LEN(cur1.len),
    .REQ1_MODE (cur1.mode),  .REQ1_LOCK  (cur1.lock), .REQ1_ACK(ack1),
    .SPI_DATA  (spi_data),   .SPI_LEN    (spi_len),   .SPI_MODE(spi_mode),
    .SPI_WE    (spi_we),     .SPI_READY  (spi_ready),
    .GRANT     (grant),      .BUSY       (busy),      .TIMEOUT_ERR(tmo)
`ifdef SPI_ARB_STATS_EN
    , .XFER_CNT0(xc0), .XFER_CNT1(xc1)
`endif
  );

  req_t q0[$], q1[$];
  int   n_assert = 0, n_fail = 0;
  int   cyc = 0, we_cnt = 0, last_we_cyc = -1, last_shift = 0, busy_cnt = 0;
  int   m_last = 1, m_lock = 0, done0 = 0, done1 = 0;
  bit   stuck = 1'b0, gap_chk = 1'b0, rand_extra = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ownership rule: lock holder only; otherwise alternate on contention, else the lone requester.
  function automatic int exp_owner();
    if (m_lock != 0) return m_last;
    if (q0.size() > 0 && q1.size() > 0) return 1 - m_last;
    if (q0.size() > 0) return 0;
    return 1;
  endfunction

  task automatic present();
    v0   = (q0.size() > 0);
    v1   = (q1.size() > 0);
    cur0 = (q0.size() > 0) ? q0[0] : '0;
    cur1 = (q1.size() > 0) ? q1[0] : '0;
  endtask

  task automatic tick();
    int   o;
    req_t head;
    @(posedge clk); #1;
    cyc++;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) spi_ready = 1'b1;
    end
    if (rst) begin spi_ready = 1'b1; busy_cnt = 0; end
    if (spi_we === 1'b1) begin
      o = exp_owner();
      we_cnt++;
      if (gap_chk && last_we_cyc >= 0) check("gap", 32'(cyc - last_we_cyc), 32'(last_shift + 3));
      check("grant", 32'(grant), (o == 1) ? 32'd2 : 32'd1);
      check("ack", 32'({ack1, ack0}), (o == 1) ? 32'd2 : 32'd1);
      check("owner_pending", 32'(((o == 1) ? q1.size() : q0.size()) > 0), 32'd1);
      head = (o == 1) ? ((q1.size() > 0) ? q1[0] : '0) : ((q0.size() > 0) ? q0[0] : '0);
      check("data", 32'(spi_data), 32'(head.data));
      check("len", 32'(spi_len), 32'(head.len));
      check("mode", 32'(spi_mode), 32'(head.mode));
      if (!stuck) begin
        spi_ready  = 1'b0;
        last_shift = int'(head.len) + 1 + (rand_extra ? int'($urandom_range(0, 3)) : 0);
        busy_cnt   = last_shift;
        m_last     = o;
        m_lock     = int'(head.lock);
        if (o == 1) done1++; else done0++;
      end else begin
        m_lock = 0;
      end
      last_we_cyc = cyc;
    end
    if (ack0 === 1'b1 && q0.size() > 0) void'(q0.pop_front());
    if (ack1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
    present();
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    bit fin = 1'b0;
    while (!fin && n < maxc) begin
      tick();
      n++;
      fin = (q0.size() == 0 && q1.size() == 0 && busy === 1'b0 && spi_ready);
    end
    check(tag, 32'(fin), 32'd1);
  endtask

  task automatic wait_we(input string tag, input int maxc);
    int n = 0;
    int w = we_cnt;
    while (we_cnt == w && n < maxc) begin tick(); n++; end
    check(tag, 32'(we_cnt != w), 32'd1);
  endtask

  initial begin
    req_t r;
    int   w, c0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_we", 32'(spi_we), 32'd0);
    check("rst_ack", 32'({ack1, ack0}), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    check("rst_data", 32'(spi_data), 32'd0);

    // T1: lone command byte, latency and single ACK pulse
    q0.push_back('{data:16'h0036, len:4'd7, mode:1'b0, lock:1'b0});
    present();
    c0 = cyc;
    wait_we("t1_we", 20);
    check("t1_latency", 32'(last_we_cyc - c0), 32'd2);
    tick();
    check("t1_ack_pulse", 32'(ack0), 32'd0);
    drain("t1_drain", 200);

    // T2: both requesters saturated, alternation and fixed spacing
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{data:16'h1000 + 16'(i), len:4'd7, mode:1'b1, lock:1'b0});
      q1.push_back('{data:16'h2000 + 16'(i), len:4'd7, mode:1'b1, lock:1'b0});
    end
    present();
    gap_chk = 1'b1; last_we_cyc = -1;
    drain("t2_drain", 500);
    gap_chk = 1'b0;

    // T3: locked command, requester 1 waits while owner is idle
    q0.push_back('{data:16'h002C, len:4'd7, mode:1'b0, lock:1'b1});
    present();
    wait_we("t3_we", 20);
    q1.push_back('{data:16'h5A5A, len:4'd7, mode:1'b1, lock:1'b0});
    present();
    w = we_cnt;
    for (int i = 0; i < 30; i++) tick();
    check("t3_hold_we", 32'(we_cnt), 32'(w));
    check("t3_hold_grant", 32'(grant), 32'd1);
    check("t3_hold_busy", 32'(busy), 32'd0);
    q0.push_back('{data:16'hF81F, len:4'd15, mode:1'b1, lock:1'b0});
    present();
    drain("t3_drain", 300);
    check("t3_order", 32'(m_last), 32'd1);

    // T4: controller never goes busy, timeout clears lock
    stuck = 1'b1;
    q0.push_back('{data:16'h00AA, len:4'd7, mode:1'b0, lock:1'b1});
    present();
    wait_we("t4_we", 20);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
    check("t4_tmo_early", 32'(tmo), 32'd0);
    check("t4_busy_early", 32'(busy), 32'd1);
    tick();
    check("t4_tmo", 32'(tmo), 32'd1);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_grant", 32'(grant), 32'd0);
    stuck = 1'b0;
    q1.push_back('{data:16'h0BB0, len:4'd7, mode:1'b1, lock:1'b0});
    present();
    drain("t4_drain", 200);
    check("t4_sticky", 32'(tmo), 32'd1);

    // T5: reset while the controller is shifting a locked word
    q0.push_back('{data:16'h0055, len:4'd15, mode:1'b1, lock:1'b1});
    present();
    wait_we("t5_we", 20);
    tick(); tick(); tick();
    rst = 1'b1;
    q0.delete(); q1.delete();
    present();
    tick();
    rst = 1'b0;
    m_last = 1; m_lock = 0; done0 = 0; done1 = 0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_we", 32'(spi_we), 32'd0);
    check("t5_tmo", 32'(tmo), 32'd0);
    q1.push_back('{data:16'h7777, len:4'd7, mode:1'b1, lock:1'b0});
    present();
    w = we_cnt;
    drain("t5_drain", 200);
    check("t5_served", 32'(we_cnt - w), 32'd1);

    // Random traffic with random locks and controller shift times
    rand_extra = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r.data = 16'($urandom); r.len = 4'($urandom); r.mode = 1'($urandom);
      r.lock = (i == 29) ? 1'b0 : ($urandom_range(0, 2) == 0);
      q0.push_back(r);
      r.data = 16'($urandom); r.len = 4'($urandom); r.mode = 1'($urandom);
      r.lock = (i == 29) ? 1'b0 : ($urandom_range(0, 2) == 0);
      q1.push_back(r);
    end
    present();
    drain("rand_drain", 5000);
    rand_extra = 1'b0;

`ifdef SPI_ARB_STATS_EN
    check("stats_cnt0", 32'(xc0), 32'(done0));
    check("stats_cnt1", 32'(xc1), 32'(done1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
